// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-enable / flush generation for the PC and the
// IF/ID, ID/EX and EX/MEM registers, with a memory-wait freeze FSM, a sticky
// memory-timeout flag and saturating stall/flush/wait performance counters.
//
//   state      | meaning
//   -----------+---------------------------------------------------------------
//   S_RUN      | normal issue; branch/hazard rules apply
//   S_MEM_WAIT | SRAM data port busy; pipeline frozen until mem_ready
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_use_src1,
    input  logic             id_use_src2,
    input  logic [3:0]       ex_dest,
    input  logic             ex_wb_en,
    input  logic             ex_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             pc_ld,
    output logic             ifid_ld,
    output logic             ifid_flush,
    output logic             idex_ld,
    output logic             idex_flush,
    output logic             exmem_ld,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    // Timer is 8 bits unless the timeout needs more.
    localparam int TMR_W = (MEM_TIMEOUT > 255) ? $clog2(MEM_TIMEOUT + 1) : 8;

    localparam logic [TMR_W-1:0] TMR_MAX = '1;
    localparam logic [TMR_W-1:0] TMR_LIM = TMR_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [0:0] S_RUN      = 1'b0;
    localparam logic [0:0] S_MEM_WAIT = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;

    logic match_src1;
    logic match_src2;
    logic hazard;
    logic freeze;
    logic branch;

    // RAW match of each ID source against ID/EX and EX/MEM destinations.
    // With forwarding only a load in EX cannot be bypassed in time.
    always_comb begin
        match_src1 = 1'b0;
        match_src2 = 1'b0;
        if (fwd_en) begin
            match_src1 = ex_wb_en & ex_mem_r_en & (ex_dest == id_src1);
            match_src2 = ex_wb_en & ex_mem_r_en & (ex_dest == id_src2);
        end else begin
            match_src1 = (ex_wb_en & (ex_dest == id_src1)) |
                         (mem_wb_en & (mem_dest == id_src1));
            match_src2 = (ex_wb_en & (ex_dest == id_src2)) |
                         (mem_wb_en & (mem_dest == id_src2));
        end
        hazard = (id_use_src1 & match_src1) | (id_use_src2 & match_src2);
    end

    // Freeze covers the RUN cycle that first sees a busy SRAM as well as
    // every MEM_WAIT cycle; the release cycle is not frozen.
    always_comb begin
        freeze = ((state == S_RUN) & mem_req & ~mem_ready) |
                 ((state == S_MEM_WAIT) & ~mem_ready);
        branch = ~freeze & ex_branch_taken;
    end

    // Prioritised control outputs: reset, freeze, branch, hazard, normal.
    always_comb begin
        pc_ld      = 1'b0;
        ifid_ld    = 1'b0;
        ifid_flush = 1'b0;
        idex_ld    = 1'b0;
        idex_flush = 1'b0;
        exmem_ld   = 1'b0;
        if (rst || freeze) begin
            pc_ld      = 1'b0;
        end else if (branch) begin
            pc_ld      = 1'b1;
            ifid_ld    = 1'b1;
            ifid_flush = 1'b1;
            idex_ld    = 1'b1;
            idex_flush = 1'b1;
            exmem_ld   = 1'b1;
        end else if (hazard) begin
            idex_ld    = 1'b1;
            idex_flush = 1'b1;
            exmem_ld   = 1'b1;
        end else begin
            pc_ld      = 1'b1;
            ifid_ld    = 1'b1;
            idex_ld    = 1'b1;
            exmem_ld   = 1'b1;
        end
    end

    // Next state and wait timer. The timer counts frozen cycles, so the RUN
    // cycle that detects the busy SRAM is the first wait cycle; it returns
    // to zero as soon as the pipeline is released.
    always_comb begin
        state_nxt = state;
        timer_nxt = '0;
        case (state)
            S_RUN:      if (mem_req & ~mem_ready) state_nxt = S_MEM_WAIT;
            S_MEM_WAIT: if (mem_ready)            state_nxt = S_RUN;
            default:                              state_nxt = S_RUN;
        endcase
        if (freeze) begin
            timer_nxt = (timer == TMR_MAX) ? TMR_MAX : timer + 1'b1;
        end
    end

    // State and timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Sticky timeout flag; the FSM keeps waiting after it is raised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_timeout <= 1'b0;
        end else if (cnt_clr) begin
            mem_timeout <= 1'b0;
        end else if (freeze && (timer_nxt >= TMR_LIM)) begin
            mem_timeout <= 1'b1;
        end
    end

    // Saturating performance counters; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (!pc_ld && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
            if (branch && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
            if (freeze && wait_cnt != CNT_MAX)  wait_cnt  <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations.
// Inputs change on the falling edge; combinational outputs are sampled 1 ns
// later, registered outputs are sampled on the falling edge after a rise.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 16;

    // {pc_ld, ifid_ld, ifid_flush, idex_ld, idex_flush, exmem_ld}
    localparam logic [5:0] C_ZERO   = 6'b000000;
    localparam logic [5:0] C_NORMAL = 6'b110101;
    localparam logic [5:0] C_BRANCH = 6'b111111;
    localparam logic [5:0] C_HAZARD = 6'b000111;

    logic             clk = 1'b0;
    logic             rst;
    logic             fwd_en;
    logic [3:0]       id_src1, id_src2;
    logic             id_use_src1, id_use_src2;
    logic [3:0]       ex_dest;
    logic             ex_wb_en, ex_mem_r_en;
    logic [3:0]       mem_dest;
    logic             mem_wb_en;
    logic             ex_branch_taken;
    logic             mem_req, mem_ready;
    logic             cnt_clr;
    logic             pc_ld, ifid_ld, ifid_flush, idex_ld, idex_flush, exmem_ld;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;
    logic [5:0]       ctl;

    int n_cmp = 0;
    int n_mis = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .pc_ld(pc_ld), .ifid_ld(ifid_ld), .ifid_flush(ifid_flush),
        .idex_ld(idex_ld), .idex_flush(idex_flush), .exmem_ld(exmem_ld),
        .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
    );

    assign ctl = {pc_ld, ifid_ld, ifid_flush, idex_ld, idex_flush, exmem_ld};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        fwd_en = 0; id_src1 = 0; id_src2 = 0; id_use_src1 = 0; id_use_src2 = 0;
        ex_dest = 0; ex_wb_en = 0; ex_mem_r_en = 0; mem_dest = 0; mem_wb_en = 0;
        ex_branch_taken = 0; mem_req = 0; mem_ready = 0; cnt_clr = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_cnts(input string tag, input int s, input int f, input int w);
        chk({tag, "_stall"}, 32'(stall_cnt), s);
        chk({tag, "_flush"}, 32'(flush_cnt), f);
        chk({tag, "_wait"},  32'(wait_cnt),  w);
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk); #2;
        chk("rst_ctl", 32'(ctl), 32'(C_ZERO));
        chk("rst_tmo", 32'(mem_timeout), 0);
        chk_cnts("rst", 0, 0, 0);
        @(negedge clk);
        rst = 0;
        #1 chk("idle_ctl", 32'(ctl), 32'(C_NORMAL));

        // Load-use with forwarding: one bubble cycle.
        fwd_en = 1; ex_wb_en = 1; ex_mem_r_en = 1; ex_dest = 3;
        id_src1 = 3; id_use_src1 = 1;
        #1 chk("lu_ctl", 32'(ctl), 32'(C_HAZARD));
        cyc();
        ex_wb_en = 0; ex_mem_r_en = 0;
        #1 chk("lu_after_ctl", 32'(ctl), 32'(C_NORMAL));
        chk_cnts("lu", 1, 0, 0);

        // Non-forwarding RAW against EX/MEM on src2.
        idle();
        mem_wb_en = 1; mem_dest = 5; id_src2 = 5; id_use_src2 = 1;
        #1 chk("raw_mem_ctl", 32'(ctl), 32'(C_HAZARD));
        cyc();
        chk_cnts("raw_mem", 2, 0, 0);
        fwd_en = 1;
        #1 chk("raw_fwd_ctl", 32'(ctl), 32'(C_NORMAL));
        cyc();
        chk("raw_fwd_stall", 32'(stall_cnt), 2);
        fwd_en = 0; id_use_src2 = 0;
        #1 chk("unused_src_ctl", 32'(ctl), 32'(C_NORMAL));
        // Non-load in EX still stalls without forwarding.
        idle();
        ex_wb_en = 1; ex_dest = 0; id_src1 = 0; id_use_src1 = 1;
        #1 chk("raw_ex_ctl", 32'(ctl), 32'(C_HAZARD));
        ex_wb_en = 0;
        #1 chk("raw_ex_clear_ctl", 32'(ctl), 32'(C_NORMAL));

        // Branch beats load-use hazard.
        idle();
        fwd_en = 1; ex_wb_en = 1; ex_mem_r_en = 1; ex_dest = 7;
        id_src1 = 7; id_use_src1 = 1; ex_branch_taken = 1;
        #1 chk("br_ctl", 32'(ctl), 32'(C_BRANCH));
        cyc();
        chk_cnts("br", 2, 1, 0);

        // Four-cycle SRAM freeze with a branch held; flush only on release.
        idle();
        mem_req = 1; ex_branch_taken = 1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("frz%0d_ctl", i), 32'(ctl), 32'(C_ZERO));
            cyc();
        end
        mem_ready = 1;
        #1 chk("rel_ctl", 32'(ctl), 32'(C_BRANCH));
        cyc();
        chk_cnts("rel", 6, 2, 4);
        chk("rel_tmo", 32'(mem_timeout), 1);
        idle();
        #1 chk("run_ctl", 32'(ctl), 32'(C_NORMAL));
        mem_req = 1; mem_ready = 1;
        #1 chk("req_rdy_ctl", 32'(ctl), 32'(C_NORMAL));
        cyc();
        chk("req_rdy_wait", 32'(wait_cnt), 4);

        // Clear, then the timeout sequence.
        idle();
        cnt_clr = 1;
        cyc();
        cnt_clr = 0;
        chk_cnts("clr1", 0, 0, 0);
        chk("clr1_tmo", 32'(mem_timeout), 0);
        mem_req = 1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk($sformatf("tmo_w%0d", i), 32'(mem_timeout), (i >= 3) ? 1 : 0);
        end
        mem_ready = 1;
        cyc();
        idle();
        chk("tmo_sticky", 32'(mem_timeout), 1);
        chk_cnts("tmo", 5, 0, 5);
        cnt_clr = 1;
        cyc();
        cnt_clr = 0;
        chk("clr2_tmo", 32'(mem_timeout), 0);
        chk_cnts("clr2", 0, 0, 0);

        // Asynchronous reset in the middle of MEM_WAIT.
        mem_req = 1;
        cyc();
        cyc();
        chk("pre_rst_wait", 32'(wait_cnt), 2);
        rst = 1;
        #1 chk("arst_ctl", 32'(ctl), 32'(C_ZERO));
        chk_cnts("arst", 0, 0, 0);
        cyc();
        idle();
        rst = 0;
        #1 chk("post_rst_ctl", 32'(ctl), 32'(C_NORMAL));
        cyc();
        chk("post_rst_stall", 32'(stall_cnt), 0);
        chk("post_rst_wait", 32'(wait_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
